// File: rtl/buzzer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_arbiter
// Purpose  : Quiz-responder front end. Synchronises four player buttons and
//            the host controls (start / correct / wrong), locks out all but
//            the first player to buzz, runs the buzz-window and answer-window
//            one-second countdowns, and emits single-cycle judgement pulses
//            with a stable player id for the downstream score keeper.
// Ports    : clk, rst (async, active-high)
//            btn_player[3:0], btn_start, btn_correct, btn_wrong : raw inputs
//            player[3:0]  : locked player id 1..4, 0 = none
//            enable       : high in LOCKED and JUDGE
//            ifCorrect    : one-clk pulse, correct judgement
//            ifWrong      : one-clk pulse, wrong judgement / answer timeout
//            false_start  : sticky, a player pressed while IDLE
//            fs_player    : id of first false-starter, 0 if none
//            timeout      : sticky, buzz window expired unanswered
//            secs_left    : seconds remaining in the active window
//            state[1:0]   : IDLE=0, ARMED=1, LOCKED=2, JUDGE=3
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_arbiter #(
    parameter int TICK_DIV    = 100000000,
    parameter int BUZZ_SECS   = 10,
    parameter int ANSWER_SECS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_player,
    input  logic       btn_start,
    input  logic       btn_correct,
    input  logic       btn_wrong,
    output logic [3:0] player,
    output logic       enable,
    output logic       ifCorrect,
    output logic       ifWrong,
    output logic       false_start,
    output logic [3:0] fs_player,
    output logic       timeout,
    output logic [5:0] secs_left,
    output logic [1:0] state
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ARMED  = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;
    localparam logic [1:0] c_JUDGE  = 2'd3;

    localparam int                 c_CNT_W     = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [5:0]         c_BUZZ      = 6'(BUZZ_SECS);
    localparam logic [5:0]         c_ANSWER    = 6'(ANSWER_SECS);

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchroniser, delayed copy, registered
    // rising-edge pulse. Bit order {wrong, correct, start, player[3:0]}.
    // ------------------------------------------------------------------
    logic [6:0] w_raw;
    logic [6:0] sync1_q;
    logic [6:0] sync2_q;
    logic [6:0] sync3_q;
    logic [6:0] edge_q;

    assign w_raw = {btn_wrong, btn_correct, btn_start, btn_player};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= w_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    logic [3:0] w_player_edge;
    logic       w_start_edge;
    logic       w_correct_edge;
    logic       w_wrong_edge;

    assign w_player_edge  = edge_q[3:0];
    assign w_start_edge   = edge_q[4];
    assign w_correct_edge = edge_q[5];
    assign w_wrong_edge   = edge_q[6];

    // Player 1 has highest priority on simultaneous presses.
    function automatic logic [3:0] lowest_id(input logic [3:0] m);
        if (m[0])      return 4'd1;
        else if (m[1]) return 4'd2;
        else if (m[2]) return 4'd3;
        else if (m[3]) return 4'd4;
        else           return 4'd0;
    endfunction

    // ------------------------------------------------------------------
    // Main state machine
    // ------------------------------------------------------------------
    logic [1:0]         state_q,  state_d;
    logic [3:0]         player_q, player_d;
    logic [5:0]         secs_q,   secs_d;
    logic [c_CNT_W-1:0] cnt_q,    cnt_d;
    logic               ifc_q,    ifc_d;
    logic               ifw_q,    ifw_d;
    logic               fs_q,     fs_d;
    logic [3:0]         fsp_q,    fsp_d;
    logic               to_q,     to_d;
    logic               w_tick;

    assign w_tick = (cnt_q == c_TICK_LAST);

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        secs_d   = secs_q;
        ifc_d    = 1'b0;
        ifw_d    = 1'b0;
        fs_d     = fs_q;
        fsp_d    = fsp_q;
        to_d     = to_q;

        case (state_q)
            c_IDLE: begin
                if (w_start_edge) begin
                    state_d = c_ARMED;
                    secs_d  = c_BUZZ;
                    fs_d    = 1'b0;
                    fsp_d   = 4'd0;
                    to_d    = 1'b0;
                end else if (|w_player_edge) begin
                    fs_d = 1'b1;
                    if (fsp_q == 4'd0) begin
                        fsp_d = lowest_id(w_player_edge);
                    end
                end
            end
            c_ARMED: begin
                // A press coinciding with expiry still wins the lock.
                if (|w_player_edge) begin
                    state_d  = c_LOCKED;
                    player_d = lowest_id(w_player_edge);
                    secs_d   = c_ANSWER;
                end else if (w_tick) begin
                    if (secs_q == 6'd1) begin
                        state_d = c_IDLE;
                        to_d    = 1'b1;
                        secs_d  = 6'd0;
                    end else begin
                        secs_d = secs_q - 6'd1;
                    end
                end
            end
            c_LOCKED: begin
                // Correct dominates wrong on the same cycle.
                if (w_correct_edge) begin
                    state_d = c_JUDGE;
                    ifc_d   = 1'b1;
                end else if (w_wrong_edge) begin
                    state_d = c_JUDGE;
                    ifw_d   = 1'b1;
                end else if (w_tick) begin
                    if (secs_q == 6'd1) begin
                        state_d = c_JUDGE;
                        ifw_d   = 1'b1;
                        secs_d  = 6'd0;
                    end else begin
                        secs_d = secs_q - 6'd1;
                    end
                end
            end
            default: begin
                // JUDGE: the pulse was raised on entry; player held through it.
                state_d  = c_IDLE;
                player_d = 4'd0;
                secs_d   = 6'd0;
            end
        endcase

        // Tick counter restarts on every state entry.
        if ((state_d != state_q) || w_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= c_IDLE;
            player_q <= 4'd0;
            secs_q   <= 6'd0;
            cnt_q    <= '0;
            ifc_q    <= 1'b0;
            ifw_q    <= 1'b0;
            fs_q     <= 1'b0;
            fsp_q    <= 4'd0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            secs_q   <= secs_d;
            cnt_q    <= cnt_d;
            ifc_q    <= ifc_d;
            ifw_q    <= ifw_d;
            fs_q     <= fs_d;
            fsp_q    <= fsp_d;
            to_q     <= to_d;
        end
    end

    assign player      = player_q;
    assign enable      = (state_q == c_LOCKED) || (state_q == c_JUDGE);
    assign ifCorrect   = ifc_q;
    assign ifWrong     = ifw_q;
    assign false_start = fs_q;
    assign fs_player   = fsp_q;
    assign timeout     = to_q;
    assign secs_left   = secs_q;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_buzzer_arbiter
// Purpose  : Self-checking bench for buzzer_arbiter with TICK_DIV=4,
//            BUZZ_SECS=3, ANSWER_SECS=2. Directed scenarios plus a random
//            run compared against a cycle-level behavioural reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_arbiter;

    localparam int TD = 4;
    localparam int BS = 3;
    localparam int AS = 2;

    localparam logic [6:0] START   = 7'b0010000;
    localparam logic [6:0] CORRECT = 7'b0100000;
    localparam logic [6:0] WRONG   = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_player;
    logic       btn_start;
    logic       btn_correct;
    logic       btn_wrong;
    logic [3:0] player;
    logic       enable;
    logic       ifCorrect;
    logic       ifWrong;
    logic       false_start;
    logic [3:0] fs_player;
    logic       timeout;
    logic [5:0] secs_left;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    buzzer_arbiter #(
        .TICK_DIV    (TD),
        .BUZZ_SECS   (BS),
        .ANSWER_SECS (AS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_player  (btn_player),
        .btn_start   (btn_start),
        .btn_correct (btn_correct),
        .btn_wrong   (btn_wrong),
        .player      (player),
        .enable      (enable),
        .ifCorrect   (ifCorrect),
        .ifWrong     (ifWrong),
        .false_start (false_start),
        .fs_player   (fs_player),
        .timeout     (timeout),
        .secs_left   (secs_left),
        .state       (state)
    );

    always #5 clk = ~clk;

    wire [20:0] obs = {player, enable, ifCorrect, ifWrong, false_start,
                       fs_player, timeout, secs_left, state};

    // ------------------------------------------------------------------
    // Reference model. A press is acted upon at the edge three edges after
    // the first edge that sampled it high (and saw it low the edge before).
    // Window remaining is derived from cycles elapsed since window start.
    // ------------------------------------------------------------------
    logic [6:0] hist [0:4];
    int         m_state;
    int         m_el;
    logic [3:0] m_player;
    logic [5:0] m_secs;
    logic       m_ifc, m_ifw, m_fs, m_to;
    logic [3:0] m_fsp;

    function automatic logic [3:0] first_of(input logic [3:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 3; i >= 0; i--) if (m[i]) r = 4'(i + 1);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [6:0] ev;
        if (rst) begin
            for (int i = 0; i < 5; i++) hist[i] = 7'd0;
            m_state = 0; m_el = 0; m_player = 0; m_secs = 0;
            m_ifc = 0; m_ifw = 0; m_fs = 0; m_to = 0; m_fsp = 0;
        end else begin
            for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {btn_wrong, btn_correct, btn_start, btn_player};
            ev = hist[3] & ~hist[4];
            m_ifc = 0;
            m_ifw = 0;
            case (m_state)
                0: begin
                    if (ev[4]) begin
                        m_state = 1; m_el = 0; m_secs = 6'(BS);
                        m_fs = 0; m_fsp = 0; m_to = 0;
                    end else if (ev[3:0] != 0) begin
                        m_fs = 1;
                        if (m_fsp == 0) m_fsp = first_of(ev[3:0]);
                    end
                end
                1: begin
                    if (ev[3:0] != 0) begin
                        m_state = 2; m_el = 0; m_secs = 6'(AS);
                        m_player = first_of(ev[3:0]);
                    end else if (m_el + 1 == BS * TD) begin
                        m_state = 0; m_to = 1; m_secs = 0;
                    end else begin
                        m_el++;
                        m_secs = 6'(BS - m_el / TD);
                    end
                end
                2: begin
                    if (ev[5]) begin
                        m_state = 3; m_ifc = 1;
                    end else if (ev[6]) begin
                        m_state = 3; m_ifw = 1;
                    end else if (m_el + 1 == AS * TD) begin
                        m_state = 3; m_ifw = 1; m_secs = 0;
                    end else begin
                        m_el++;
                        m_secs = 6'(AS - m_el / TD);
                    end
                end
                default: begin
                    m_state = 0; m_player = 0; m_secs = 0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic drive(input logic [6:0] v);
        {btn_wrong, btn_correct, btn_start, btn_player} = v;
    endtask

    task automatic press(input logic [6:0] v);
        drive(v);
        @(negedge clk);
        drive(7'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        drive(7'd0);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        drive(7'd0);
        rst = 1'b1;
        cycles(2);
        n_checks++;
        if (obs !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h expected 0", obs);
        end
        rst = 1'b0;
        cycles(3);
        n_checks++;
        if (obs !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h expected 0", obs);
        end
    endtask

    task automatic test_lock_correct;
        do_reset();
        press(START);
        cycles(2);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL start_latency_early: state=%0d expected 0", state);
        end
        cycles(1);
        n_checks++;
        if (state !== 2'd1 || secs_left !== 6'(BS)) begin
            n_fail++;
            $display("FAIL armed: state=%0d secs=%0d expected 1/%0d", state, secs_left, BS);
        end
        press({3'b000, 4'b0100});
        cycles(3);
        n_checks++;
        if (state !== 2'd2 || player !== 4'd3 || enable !== 1'b1 || secs_left !== 6'(AS)) begin
            n_fail++;
            $display("FAIL lock_p3: state=%0d player=%0d en=%b secs=%0d expected 2/3/1/%0d",
                     state, player, enable, secs_left, AS);
        end
        press(CORRECT);
        cycles(3);
        n_checks++;
        if (ifCorrect !== 1'b1 || ifWrong !== 1'b0 || player !== 4'd3 || state !== 2'd3 || enable !== 1'b1) begin
            n_fail++;
            $display("FAIL correct_pulse: ifc=%b ifw=%b player=%0d state=%0d en=%b expected 1/0/3/3/1",
                     ifCorrect, ifWrong, player, state, enable);
        end
        cycles(1);
        n_checks++;
        if (ifCorrect !== 1'b0 || player !== 4'd0 || enable !== 1'b0 || state !== 2'd0 || secs_left !== 6'd0) begin
            n_fail++;
            $display("FAIL after_judge: ifc=%b player=%0d en=%b state=%0d secs=%0d expected all 0",
                     ifCorrect, player, enable, state, secs_left);
        end
    endtask

    task automatic test_priority;
        do_reset();
        press(START);
        cycles(3);
        press({3'b000, 4'b1010});
        cycles(3);
        n_checks++;
        if (player !== 4'd2 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL prio_player: player=%0d state=%0d expected 2/2", player, state);
        end
        press(CORRECT | WRONG);
        cycles(3);
        n_checks++;
        if (ifCorrect !== 1'b1 || ifWrong !== 1'b0) begin
            n_fail++;
            $display("FAIL both_host: ifc=%b ifw=%b expected 1/0", ifCorrect, ifWrong);
        end
        cycles(1);
        n_checks++;
        if (ifWrong !== 1'b0 || ifCorrect !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL both_host_after: ifc=%b ifw=%b state=%0d expected 0/0/0", ifCorrect, ifWrong, state);
        end
    endtask

    task automatic test_buzz_timeout;
        int es;
        int est;
        do_reset();
        press(START);
        cycles(3);
        for (int j = 1; j <= BS * TD; j++) begin
            cycles(1);
            es  = (j < BS * TD) ? (BS - j / TD) : 0;
            est = (j < BS * TD) ? 1 : 0;
            n_checks++;
            if (secs_left !== 6'(es) || state !== 2'(est) || ifCorrect !== 1'b0 ||
                ifWrong !== 1'b0 || player !== 4'd0 || timeout !== (j == BS * TD)) begin
                n_fail++;
                $display("FAIL buzz_window[%0d]: secs=%0d state=%0d ifc=%b ifw=%b player=%0d to=%b expected %0d/%0d/0/0/0/%0d",
                         j, secs_left, state, ifCorrect, ifWrong, player, timeout, es, est, (j == BS * TD));
            end
        end
    endtask

    task automatic test_answer_timeout;
        do_reset();
        press(START);
        cycles(3);
        press({3'b000, 4'b1000});
        cycles(3);
        n_checks++;
        if (player !== 4'd4 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL lock_p4: player=%0d state=%0d expected 4/2", player, state);
        end
        for (int j = 1; j <= AS * TD; j++) begin
            cycles(1);
            n_checks++;
            if (j < AS * TD) begin
                if (ifWrong !== 1'b0 || state !== 2'd2) begin
                    n_fail++;
                    $display("FAIL answer_wait[%0d]: ifw=%b state=%0d expected 0/2", j, ifWrong, state);
                end
            end else begin
                if (ifWrong !== 1'b1 || ifCorrect !== 1'b0 || player !== 4'd4 || state !== 2'd3) begin
                    n_fail++;
                    $display("FAIL answer_expire: ifw=%b ifc=%b player=%0d state=%0d expected 1/0/4/3",
                             ifWrong, ifCorrect, player, state);
                end
            end
        end
        cycles(1);
        n_checks++;
        if (ifWrong !== 1'b0 || state !== 2'd0 || player !== 4'd0) begin
            n_fail++;
            $display("FAIL answer_after: ifw=%b state=%0d player=%0d expected 0/0/0", ifWrong, state, player);
        end
    endtask

    task automatic test_false_start;
        do_reset();
        press({3'b000, 4'b0001});
        cycles(3);
        n_checks++;
        if (false_start !== 1'b1 || fs_player !== 4'd1 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL fs_first: fs=%b fsp=%0d state=%0d expected 1/1/0", false_start, fs_player, state);
        end
        press({3'b000, 4'b0010});
        cycles(3);
        n_checks++;
        if (false_start !== 1'b1 || fs_player !== 4'd1) begin
            n_fail++;
            $display("FAIL fs_second: fs=%b fsp=%0d expected 1/1", false_start, fs_player);
        end
        press(START);
        cycles(3);
        n_checks++;
        if (false_start !== 1'b0 || fs_player !== 4'd0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL fs_clear: fs=%b fsp=%0d state=%0d expected 0/0/1", false_start, fs_player, state);
        end
    endtask

    task automatic test_reset_locked;
        do_reset();
        press(START);
        cycles(3);
        press({3'b000, 4'b0010});
        cycles(3);
        press(CORRECT);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%h expected 0", obs);
        end
        cycles(3);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            cycles(1);
            n_checks++;
            if (ifCorrect !== 1'b0 || ifWrong !== 1'b0 || state !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_no_pulse[%0d]: ifc=%b ifw=%b state=%0d expected 0/0/0",
                         j, ifCorrect, ifWrong, state);
            end
        end
    endtask

    task automatic test_random;
        logic [6:0] v;
        logic [20:0] exp;
        int dens;
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            dens = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 9 : 40);
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                exp = {m_player, (m_state == 2 || m_state == 3), m_ifc, m_ifw, m_fs,
                       m_fsp, m_to, m_secs, 2'(m_state)};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL random[%0d]: outputs=%h expected %h", blk * 500 + c, obs, exp);
                end
                for (int b = 0; b < 7; b++) v[b] = ($urandom_range(dens - 1) == 0);
                drive(v);
            end
        end
        drive(7'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(7'd0);
        test_reset();
        test_lock_correct();
        test_priority();
        test_buzz_timeout();
        test_answer_timeout();
        test_false_start();
        test_reset_locked();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
